// File: rtl/ov5640_cfg_pkg.sv
// Shared definitions for the OV5640 init-register sequencer.
// Includes the state encoding, the ROM word field positions and a microsecond-to-cycle helper.
package ov5640_cfg_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_PWR_WAIT,
        ST_FETCH,
        ST_LATCH,
        ST_WAIT_ACK,
        ST_DELAY,
        ST_NEXT,
        ST_DONE,
        ST_ERROR
    } cfg_state_t;

    localparam int unsigned REG_ADDR_MSB = 23;
    localparam int unsigned REG_ADDR_LSB = 8;
    localparam int unsigned REG_DATA_MSB = 7;

    function automatic int unsigned us_to_cycles(input int unsigned delay_us,
                                                 input int unsigned clk_freq);
        return delay_us * (clk_freq / 1_000_000);
    endfunction

endpackage

// File: rtl/ov5640_cfg_sequencer_timer.sv
// Down-counting delay timer. It is loaded by start and counts down to zero.
// expired is high for one cycle when the count reaches zero, so a load of N gives N+1 cycles.
module cfg_delay_timer #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CNT_W-1:0] load,
    input  logic             start,
    output logic             expired
);

    logic [CNT_W-1:0] count;
    logic             running;

    always_ff @(posedge clk) begin
        if (reset) begin
            count   <= '0;
            running <= 1'b0;
        end else if (start) begin
            count   <= load;
            running <= 1'b1;
        end else if (running) begin
            if (count == '0) begin
                running <= 1'b0;
            end else begin
                count <= count - CNT_W'(1);
            end
        end
    end

    assign expired = running && (count == '0);

endmodule

// File: rtl/ov5640_cfg_sequencer.sv
// Walks the OV5640 init ROM and issues one SCCB write per entry.
// It adds the power-up and soft-reset settle delays, retries NACKed writes and reports done or error.
module ov5640_cfg_sequencer
    import ov5640_cfg_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 24,
    parameter int unsigned ADDR_WIDTH     = 8,
    parameter int unsigned REG_NUM        = 250,
    parameter int unsigned CLK_FREQ       = 50_000_000,
    parameter int unsigned PWRUP_DELAY_US = 20_000,
    parameter int unsigned RST_DELAY_US   = 5_000,
    parameter int unsigned RST_INDEX      = 1,
    parameter int unsigned RETRY_MAX      = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_q,
    output logic                  wr_req,
    output logic [15:0]           wr_addr,
    output logic [7:0]            wr_data,
    input  logic                  wr_done,
    input  logic                  wr_err,
    output logic                  init_busy,
    output logic                  init_done,
    output logic                  init_err,
    output logic [ADDR_WIDTH-1:0] err_index
);

    if (REG_NUM == 0 || REG_NUM > (2 ** ADDR_WIDTH)) begin : g_bad_reg_num
        $error("REG_NUM (%0d) must be in 1..2**ADDR_WIDTH", REG_NUM);
    end

    localparam int unsigned PWR_CYC = us_to_cycles(PWRUP_DELAY_US, CLK_FREQ);
    localparam int unsigned RST_CYC = us_to_cycles(RST_DELAY_US, CLK_FREQ);
    localparam int unsigned MAX_CYC = (PWR_CYC > RST_CYC) ? PWR_CYC : RST_CYC;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC) + 1;
    localparam int unsigned RETRY_W = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;

    // The timer runs load+1 cycles, so N-1 is loaded to spend N cycles in the wait state (minimum 1).
    localparam logic [CNT_W-1:0] PWR_LOAD = CNT_W'((PWR_CYC > 0) ? PWR_CYC - 1 : 0);
    localparam logic [CNT_W-1:0] RST_LOAD = CNT_W'((RST_CYC > 0) ? RST_CYC - 1 : 0);

    localparam logic [ADDR_WIDTH-1:0] LAST_INDEX = ADDR_WIDTH'(REG_NUM - 1);
    localparam logic [ADDR_WIDTH-1:0] RST_ENTRY  = ADDR_WIDTH'(RST_INDEX);
    localparam logic [RETRY_W-1:0]    RETRY_LIM  = RETRY_W'(RETRY_MAX);

    cfg_state_t            state, state_next;
    logic [ADDR_WIDTH-1:0] index, index_next;
    logic [RETRY_W-1:0]    retry, retry_next;
    logic                  wr_req_next;
    logic [15:0]           wr_addr_next;
    logic [7:0]            wr_data_next;
    logic                  busy_next, done_next, err_next;
    logic [ADDR_WIDTH-1:0] err_index_next;
    logic                  tmr_start, tmr_expired;
    logic [CNT_W-1:0]      tmr_load;

    cfg_delay_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .load    (tmr_load),
        .start   (tmr_start),
        .expired (tmr_expired)
    );

    // The ROM output is registered, so driving the address from index lets FETCH present it one cycle ahead of LATCH.
    assign rom_addr = index;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            index     <= '0;
            retry     <= '0;
            wr_req    <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            init_busy <= 1'b0;
            init_done <= 1'b0;
            init_err  <= 1'b0;
            err_index <= '0;
        end else begin
            state     <= state_next;
            index     <= index_next;
            retry     <= retry_next;
            wr_req    <= wr_req_next;
            wr_addr   <= wr_addr_next;
            wr_data   <= wr_data_next;
            init_busy <= busy_next;
            init_done <= done_next;
            init_err  <= err_next;
            err_index <= err_index_next;
        end
    end

    always_comb begin
        state_next     = state;
        index_next     = index;
        retry_next     = retry;
        wr_req_next    = wr_req;
        wr_addr_next   = wr_addr;
        wr_data_next   = wr_data;
        busy_next      = init_busy;
        done_next      = init_done;
        err_next       = init_err;
        err_index_next = err_index;
        tmr_start      = 1'b0;
        tmr_load       = '0;

        unique case (state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    state_next = ST_PWR_WAIT;
                    index_next = '0;
                    retry_next = '0;
                    busy_next  = 1'b1;
                    done_next  = 1'b0;
                    err_next   = 1'b0;
                    tmr_start  = 1'b1;
                    tmr_load   = PWR_LOAD;
                end
            end
            ST_PWR_WAIT: begin
                if (tmr_expired) state_next = ST_FETCH;
            end
            ST_FETCH: begin
                state_next = ST_LATCH;
            end
            ST_LATCH: begin
                wr_addr_next = rom_q[REG_ADDR_MSB:REG_ADDR_LSB];
                wr_data_next = rom_q[REG_DATA_MSB:0];
                wr_req_next  = 1'b1;
                state_next   = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                // An error pulse takes priority over a simultaneous done pulse.
                if (wr_err) begin
                    wr_req_next = 1'b0;
                    if (retry < RETRY_LIM) begin
                        retry_next = retry + RETRY_W'(1);
                        state_next = ST_LATCH;
                    end else begin
                        err_index_next = index;
                        busy_next      = 1'b0;
                        err_next       = 1'b1;
                        state_next     = ST_ERROR;
                    end
                end else if (wr_done) begin
                    wr_req_next = 1'b0;
                    retry_next  = '0;
                    if (index == RST_ENTRY) begin
                        state_next = ST_DELAY;
                        tmr_start  = 1'b1;
                        tmr_load   = RST_LOAD;
                    end else begin
                        state_next = ST_NEXT;
                    end
                end
            end
            ST_DELAY: begin
                if (tmr_expired) state_next = ST_NEXT;
            end
            ST_NEXT: begin
                if (index == LAST_INDEX) begin
                    busy_next  = 1'b0;
                    done_next  = 1'b1;
                    state_next = ST_DONE;
                end else begin
                    index_next = index + ADDR_WIDTH'(1);
                    state_next = ST_FETCH;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_ov5640_cfg_sequencer.sv
// Scoreboard bench for ov5640_cfg_sequencer, using a behavioural ROM and an SCCB responder.
// Each expected write is queued with its expected gap after the previous done/err pulse.
module tb_ov5640_cfg_sequencer;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [7:0]  rom_addr;
    logic [23:0] rom_q;
    logic        wr_req, wr_done, wr_err;
    logic [15:0] wr_addr;
    logic [7:0]  wr_data;
    logic        init_busy, init_done, init_err;
    logic [7:0]  err_index;

    typedef struct {
        logic [23:0] word;
        int          gap;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   nack_plan[8];
    int   both_plan[8];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ov5640_cfg_sequencer #(
        .DATA_WIDTH     (24),
        .ADDR_WIDTH     (8),
        .REG_NUM        (8),
        .CLK_FREQ       (1_000_000),
        .PWRUP_DELAY_US (10),
        .RST_DELAY_US   (20),
        .RST_INDEX      (1),
        .RETRY_MAX      (3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .rom_addr  (rom_addr),
        .rom_q     (rom_q),
        .wr_req    (wr_req),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_done   (wr_done),
        .wr_err    (wr_err),
        .init_busy (init_busy),
        .init_done (init_done),
        .init_err  (init_err),
        .err_index (err_index)
    );

    function automatic logic [23:0] rom_word(input logic [7:0] a);
        case (a)
            8'd0:    return 24'h310311;
            8'd1:    return 24'h300882;
            8'd2:    return 24'h300842;
            8'd3:    return 24'h310303;
            8'd4:    return 24'h3017FF;
            8'd5:    return 24'h3018FF;
            8'd6:    return 24'h30341A;
            8'd7:    return 24'h303713;
            default: return 24'h000000;
        endcase
    endfunction

    always @(posedge clk) rom_q <= rom_word(rom_addr);

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Gap = idle cycles between the done/err cycle and the wr_req rise: 3 normally, 20+3 after the soft reset, 1 on retry.
    task automatic push_seq(input int last, input int rep_idx, input int reps);
        for (int i = 0; i <= last; i++) begin
            int g;
            g = (i == 0) ? -1 : ((i == 2) ? 23 : 3);
            exp_q.push_back('{word: rom_word(8'(i)), gap: g});
            if (i == rep_idx)
                for (int r = 0; r < reps; r++)
                    exp_q.push_back('{word: rom_word(8'(i)), gap: 1});
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_end(input string name);
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            if (init_done || init_err) break;
        end
        check({name, "_finished"}, 32'(init_done || init_err), 32'd1);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_wr_req"},    32'(wr_req),    32'd0);
        check({name, "_rom_addr"},  32'(rom_addr),  32'd0);
        check({name, "_wr_addr"},   32'(wr_addr),   32'd0);
        check({name, "_wr_data"},   32'(wr_data),   32'd0);
        check({name, "_busy"},      32'(init_busy), 32'd0);
        check({name, "_done"},      32'(init_done), 32'd0);
        check({name, "_err"},       32'(init_err),  32'd0);
        check({name, "_err_index"}, 32'(err_index), 32'd0);
    endtask

    // This SCCB responder answers 3 cycles after it first sees wr_req, and it abandons the write if wr_req drops.
    initial begin
        wr_done = 1'b0;
        wr_err  = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (wr_req) begin
                int  idx;
                bit  aborted;
                idx = 0;
                aborted = 1'b0;
                for (int i = 0; i < 8; i++)
                    if (rom_word(8'(i)) == {wr_addr, wr_data}) idx = i;
                for (int k = 0; k < 3; k++) begin
                    @(posedge clk); #1;
                    if (!wr_req) aborted = 1'b1;
                end
                if (!aborted) begin
                    if (both_plan[idx] > 0) begin
                        both_plan[idx]--;
                        wr_done = 1'b1;
                        wr_err  = 1'b1;
                    end else if (nack_plan[idx] > 0) begin
                        nack_plan[idx]--;
                        wr_err = 1'b1;
                    end else begin
                        wr_done = 1'b1;
                    end
                    @(posedge clk); #1;
                    wr_done = 1'b0;
                    wr_err  = 1'b0;
                end
            end
        end
    end

    // The monitor pops one expected write per wr_req rise and checks that the data holds while the request is high.
    initial begin
        logic        req_prev;
        logic [23:0] held;
        int          last_resp;
        req_prev  = 1'b0;
        held      = '0;
        last_resp = 0;
        forever begin
            @(negedge clk);
            if (wr_req && !req_prev) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_write: got %06h expected no write (t=%0t)",
                             {wr_addr, wr_data}, $time);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("write_addr", 32'(wr_addr), 32'(e.word[23:8]));
                    check("write_data", 32'(wr_data), 32'(e.word[7:0]));
                    if (e.gap >= 0) check("write_gap", 32'(cyc - last_resp - 1), 32'(e.gap));
                end
                held = {wr_addr, wr_data};
            end else if (wr_req && req_prev) begin
                check("write_stable", 32'({wr_addr, wr_data}), 32'(held));
            end
            if (wr_done || wr_err) last_resp = cyc;
            req_prev = wr_req;
        end
    end

    initial begin
        bit found;
        for (int i = 0; i < 8; i++) begin
            nack_plan[i] = 0;
            both_plan[i] = 0;
        end
        reset = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        reset = 1'b0;
        @(posedge clk); #1;

        // Happy path, with a start pulse during the soft-reset delay that must be ignored.
        push_seq(7, -1, 0);
        pulse_start();
        check("t1_busy", 32'(init_busy), 32'd1);
        repeat (30) @(posedge clk);
        #1;
        pulse_start();
        check("t1_busy_after_ignored_start", 32'(init_busy), 32'd1);
        wait_end("t1");
        check("t1_done", 32'(init_done), 32'd1);
        check("t1_busy_end", 32'(init_busy), 32'd0);
        check("t1_err", 32'(init_err), 32'd0);
        check("t1_queue_empty", 32'(exp_q.size()), 32'd0);

        // Rerun from DONE: index 4 is NACKed twice and then ACKed.
        nack_plan[4] = 2;
        push_seq(7, 4, 2);
        pulse_start();
        check("t3_done_cleared", 32'(init_done), 32'd0);
        check("t3_busy", 32'(init_busy), 32'd1);
        wait_end("t3");
        check("t3_done", 32'(init_done), 32'd1);
        check("t3_err", 32'(init_err), 32'd0);
        check("t3_queue_empty", 32'(exp_q.size()), 32'd0);

        // wr_done and wr_err together on index 6 count as a NACK.
        both_plan[6] = 1;
        push_seq(7, 6, 1);
        pulse_start();
        wait_end("t6");
        check("t6_done", 32'(init_done), 32'd1);
        check("t6_err", 32'(init_err), 32'd0);
        check("t6_queue_empty", 32'(exp_q.size()), 32'd0);

        // Retry exhaustion: index 5 is NACKed on all four attempts.
        nack_plan[5] = 4;
        push_seq(5, 5, 3);
        pulse_start();
        wait_end("t4");
        check("t4_err", 32'(init_err), 32'd1);
        check("t4_done", 32'(init_done), 32'd0);
        check("t4_busy", 32'(init_busy), 32'd0);
        check("t4_err_index", 32'(err_index), 32'd5);
        check("t4_wr_req", 32'(wr_req), 32'd0);
        repeat (40) @(posedge clk);
        #1;
        check("t4_queue_empty", 32'(exp_q.size()), 32'd0);
        check("t4_err_sticky", 32'(init_err), 32'd1);

        // Restart from ERROR, then assert reset while index 3 is being written.
        push_seq(3, -1, 0);
        pulse_start();
        check("t5_err_cleared", 32'(init_err), 32'd0);
        found = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(posedge clk); #1;
            if (wr_req && {wr_addr, wr_data} == rom_word(8'd3)) begin
                found = 1'b1;
                break;
            end
        end
        check("t5_reached_index3", 32'(found), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        check_reset_outputs("t5_midwrite_reset");
        reset = 1'b0;
        check("t5_queue_empty", 32'(exp_q.size()), 32'd0);
        repeat (5) @(posedge clk);
        #1;
        push_seq(7, -1, 0);
        pulse_start();
        wait_end("t5_rerun");
        check("t5_done", 32'(init_done), 32'd1);
        check("t5_rerun_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
